// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the bitwise logic pipeline.
// Contents:
//   OP_NOT..OP_PASS : 3-bit operation codes
//   state_t         : output-buffer occupancy state (EMPTY / ONE / FULL)
package bitwise_logic_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_logic_op.sv
// Combinational bitwise operation unit; the only place op codes are decoded.
// Ports:
//   a, b : WIDTH-bit operands (b ignored for NOT and PASS)
//   op   : 3-bit operation select
//   y    : WIDTH-bit result, same width as operands
module bitwise_logic_op #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);
    import bitwise_logic_pkg::*;

    // Operation decode.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic pipeline with valid/ready handshakes on both sides
// and a two-entry output buffer (output register + skid register), so that a
// full result per cycle is sustained and in_ready never depends
// combinationally on out_ready.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : upstream handshake for in_a, in_b, in_op
//   out_valid/out_ready: downstream handshake for out_y, out_op
//   op_count           : completed output handshakes since reset, wrapping
module bitwise_logic_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] op_count
);
    import bitwise_logic_pkg::*;

    state_t           state_r;
    state_t           state_next_s;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [WIDTH-1:0] oreg_y_r;
    logic [2:0]       oreg_op_r;
    logic [WIDTH-1:0] sreg_y_r;
    logic [2:0]       sreg_op_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] op_y_s;
    logic             accept_s;
    logic             emit_s;
    logic             load_oreg_in_s;
    logic             load_oreg_skid_s;
    logic             load_sreg_s;

    bitwise_logic_op #(.WIDTH(WIDTH)) u_op (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .y  (op_y_s)
    );

    assign accept_s  = in_valid & in_ready_r;
    assign emit_s    = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_y     = oreg_y_r;
    assign out_op    = oreg_op_r;
    assign op_count  = count_r;

    // Next-state and register-load decisions for the output buffer.
    always_comb begin
        state_next_s     = state_r;
        load_oreg_in_s   = 1'b0;
        load_oreg_skid_s = 1'b0;
        load_sreg_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_oreg_in_s = 1'b1;
                    state_next_s   = ST_ONE;
                end else begin
                    state_next_s   = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && emit_s) begin
                    load_oreg_in_s = 1'b1;
                    state_next_s   = ST_ONE;
                end else if (accept_s) begin
                    // Downstream stalled: park the new result behind OREG.
                    load_sreg_s    = 1'b1;
                    state_next_s   = ST_FULL;
                end else if (emit_s) begin
                    state_next_s   = ST_EMPTY;
                end else begin
                    state_next_s   = ST_ONE;
                end
            end
            ST_FULL: begin
                if (emit_s) begin
                    load_oreg_skid_s = 1'b1;
                    state_next_s     = ST_ONE;
                end else begin
                    state_next_s     = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s != ST_EMPTY);
            in_ready_r  <= (state_next_s != ST_FULL);
        end
    end

    // Output register: fed from the op unit or from the skid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_y_r  <= {WIDTH{1'b0}};
            oreg_op_r <= 3'b000;
        end else if (load_oreg_in_s) begin
            oreg_y_r  <= op_y_s;
            oreg_op_r <= in_op;
        end else if (load_oreg_skid_s) begin
            oreg_y_r  <= sreg_y_r;
            oreg_op_r <= sreg_op_r;
        end
    end

    // Skid register: holds the second result while downstream is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_y_r  <= {WIDTH{1'b0}};
            sreg_op_r <= 3'b000;
        end else if (load_sreg_s) begin
            sreg_y_r  <= op_y_s;
            sreg_op_r <= in_op;
        end
    end

    // Completed-operation counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (emit_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
// A second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_bitwise_logic_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = 4'b0000;
    logic [3:0] in_b = 4'b0000;
    logic [2:0] in_op = 3'b000;
    logic       out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [3:0]  out_y;
    logic [2:0]  out_op;
    logic [15:0] op_count;

    logic        in_ready2, out_valid2;
    logic [3:0]  out_y2;
    logic [2:0]  out_op2;
    logic [1:0]  op_count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .op_count(op_count)
    );

    bitwise_logic_pipe #(.WIDTH(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
        .out_ready(out_ready), .out_y(out_y2), .out_op(out_op2), .op_count(op_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: truth table per op, indexed by {a_bit, b_bit}.
    logic [3:0] tt [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                           4'b0111, 4'b0001, 4'b1001, 4'b1100};

    function automatic logic [3:0] model_y(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        logic [3:0] r;
        logic [3:0] row;
        row = tt[op];
        for (int i = 0; i < 4; i++) r[i] = row[{a[i], b[i]}];
        return r;
    endfunction

    // Model state: FIFO of {op, y} of at most two entries.
    logic [6:0] q[$];
    int         emits  = 0;
    logic       ir_exp = 1'b0;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        logic acc, emt;
        if (rst) begin
            q.delete();
            emits  = 0;
            ir_exp = 1'b0;
            chk_en = 1'b1;
        end else begin
            acc = in_valid && ir_exp;
            emt = (q.size() > 0) && out_ready;
            if (emt) begin
                void'(q.pop_front());
                emits++;
            end
            if (acc) q.push_back({in_op, model_y(in_a, in_b, in_op)});
            ir_exp = (q.size() < 2);
        end
    end

    // Compare DUT outputs with the model every cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("mdl_in_ready", 32'(in_ready), 32'(ir_exp));
            chk("mdl_op_count", 32'(op_count), 32'(emits % 65536));
            chk("mdl_op_count2", 32'(op_count2), 32'(emits % 4));
            chk("mdl2_out_valid", 32'(out_valid2), 32'(q.size() > 0));
            chk("mdl2_in_ready", 32'(in_ready2), 32'(ir_exp));
            if (q.size() > 0) begin
                chk("mdl_out_y", 32'(out_y), 32'(q[0][3:0]));
                chk("mdl_out_op", 32'(out_op), 32'(q[0][6:4]));
                chk("mdl2_out_y", 32'(out_y2), 32'(q[0][3:0]));
                chk("mdl2_out_op", 32'(out_op2), 32'(q[0][6:4]));
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] ops_exp [7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                                4'b0001, 4'b1001, 4'b1100};

    initial begin
        int sent;
        int cyc;
        logic acc;
        logic [3:0] ra, rb;
        logic [2:0] rop;

        // Reset
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // NOT stream, out_ready=1
        step(1'b1, 4'b0000, 4'h0, 3'd0, 1'b1);
        chk("not_0000", 32'(out_y), 32'b1111);
        step(1'b1, 4'b1010, 4'h0, 3'd0, 1'b1);
        chk("not_1010", 32'(out_y), 32'b0101);
        chk("cnt2_a", 32'(op_count2), 32'd1);
        step(1'b1, 4'b1111, 4'h0, 3'd0, 1'b1);
        chk("not_1111", 32'(out_y), 32'b0000);
        chk("cnt2_b", 32'(op_count2), 32'd2);
        step(1'b1, 4'b1100, 4'h0, 3'd0, 1'b1);
        chk("not_1100", 32'(out_y), 32'b0011);
        chk("cnt2_c", 32'(op_count2), 32'd3);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("not_count", 32'(op_count), 32'd4);
        chk("cnt2_wrap", 32'(op_count2), 32'd0);

        // All binary ops on a=1100, b=1010
        for (int k = 1; k < 8; k++) begin
            step(1'b1, 4'b1100, 4'b1010, 3'(k), 1'b1);
            chk("ops_y", 32'(out_y), 32'(ops_exp[k-1]));
            chk("ops_op", 32'(out_op), 32'(k));
            if (k == 2) chk("cnt2_after_wrap", 32'(op_count2), 32'd1);
        end
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("ops_count", 32'(op_count), 32'd11);

        // Backpressure
        step(1'b1, 4'b0000, 4'h0, 3'd0, 1'b0);
        chk("bp_first_y", 32'(out_y), 32'b1111);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        step(1'b1, 4'b1111, 4'b0011, 3'd1, 1'b0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_held_y", 32'(out_y), 32'b1111);
        step(1'b1, 4'b0101, 4'b0011, 3'd2, 1'b0);
        chk("bp_held_off", 32'(in_ready), 32'd0);
        chk("bp_still_y", 32'(out_y), 32'b1111);
        step(1'b1, 4'b0101, 4'b0011, 3'd2, 1'b1);
        chk("bp_second_y", 32'(out_y), 32'b0011);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_count_a", 32'(op_count), 32'd12);
        step(1'b1, 4'b0101, 4'b0011, 3'd2, 1'b1);
        chk("bp_third_y", 32'(out_y), 32'b0111);
        chk("bp_count_b", 32'(op_count), 32'd13);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_count_c", 32'(op_count), 32'd14);

        // Pseudo-random stream of 16 ops with toggling out_ready
        sent = 0;
        cyc  = 0;
        ra  = 4'($urandom);
        rb  = 4'($urandom);
        rop = 3'($urandom);
        while (sent < 16 && cyc < 300) begin
            in_valid  = 1'b1;
            in_a      = ra;
            in_b      = rb;
            in_op     = rop;
            out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) begin
                sent++;
                ra  = 4'($urandom);
                rb  = 4'($urandom);
                rop = 3'($urandom);
            end
            cyc++;
        end
        chk("stream_sent", 32'(sent), 32'd16);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 10 && out_valid; d++) begin
            @(posedge clk);
            #2;
        end
        chk("stream_drain", 32'(out_valid), 32'd0);
        chk("stream_sb_empty", 32'(q.size()), 32'd0);
        chk("stream_count", 32'(op_count), 32'd30);

        // Reset while FULL
        step(1'b1, 4'b0001, 4'h0, 3'd0, 1'b0);
        step(1'b1, 4'b0010, 4'h0, 3'd0, 1'b0);
        chk("rf_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("rf_out_valid", 32'(out_valid), 32'd0);
        chk("rf_in_ready", 32'(in_ready), 32'd0);
        chk("rf_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("rf_ready_back", 32'(in_ready), 32'd1);
        chk("rf_empty", 32'(out_valid), 32'd0);
        step(1'b1, 4'b1001, 4'h0, 3'd0, 1'b1);
        chk("rf_next_y", 32'(out_y), 32'b0110);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
        chk("rf_next_count", 32'(op_count), 32'd1);
        chk("rf_next_done", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
